blink: RTL and testbench
========================

# blink

Free-running LED blinker for the board's status LED. Derives a fixed-rate, fixed-duty square wave from the system clock with a modulo period counter and drives one active-high LED output. It needs no control inputs. It sits at the top level, directly on the board clock and the LED pin.

## Interface
Parameters:
- `CLK_HZ`, default 100_000_000: input clock frequency in Hz.
- `BLINK_HZ`, default 1: LED blink frequency in Hz.
- `DUTY_PCT`, default 50: percentage of each period the LED is on, range 0..100.

Ports:
- `clk`  input  1  system clock; all logic on its rising edge.
- `rst_n`  input  1  reset; one clock; reset is asynchronous and active-low.
- `led`  output  1  LED drive, active-high, registered.

## Operation
- Derived constants, integer arithmetic at elaboration:
  - `PERIOD = CLK_HZ / BLINK_HZ`, truncating.
  - `ON_CYC = (PERIOD * DUTY_PCT) / 100`, truncating.
  - Products are computed in at least 64-bit.
- Counter `cnt`:
  - Width `$clog2(PERIOD)`, minimum 1.
  - Counts 0..PERIOD-1, then wraps to 0.
- Each rising edge:
  - `cnt <= (cnt == PERIOD-1) ? 0 : cnt + 1`.
  - `led <= (cnt < ON_CYC)`.
- `DUTY_PCT` = 0 gives `ON_CYC` = 0, so `led` is constantly 0.
- `DUTY_PCT` = 100 gives `ON_CYC` = `PERIOD`, so `led` is constantly 1 after the first edge.
- Elaboration error (`$error` in a generate check) if any of these holds:
  - `BLINK_HZ` = 0.
  - `PERIOD` < 2.
  - `DUTY_PCT` > 100.

## Timing
- Reset asserted: `cnt` = 0 and `led` = 0 immediately, without waiting for a clock edge.
- First rising edge after `rst_n` deasserts: `led` goes to 1 if `ON_CYC` > 0.
- After that first edge, each period is `ON_CYC` cycles high followed by `PERIOD - ON_CYC` cycles low. The period is exactly `PERIOD` clocks.
- Latency from counter value to `led` is one cycle. The phase is fixed relative to reset release.
- Reset asserted mid-period:
  - `led` drops to 0 asynchronously.
  - The sequence restarts from `cnt` = 0 on release.
- Deassertion of `rst_n` is synchronised externally. The block does not add a reset synchroniser.
- No glitches on `led`: it is driven directly from a flop.

## Structure
- Shared package `blink_pkg` holds:
  - `function automatic int blink_period(longint clk_hz, longint blink_hz)`;
  - `function automatic int blink_on_cycles(int period, int duty_pct)`;
  - the width helper.
- Natural sub-module `blink_period_ctr`:
  - parameter `PERIOD`;
  - outputs `cnt` and a `wrap` pulse on `cnt == PERIOD-1`;
  - same async active-low reset.
- `blink` instantiates `blink_period_ctr` and adds the compare-and-register stage for `led`.

## Test plan
All scenarios use `CLK_HZ`=10, `BLINK_HZ`=1 unless stated.
- Reset: hold `rst_n`=0 for 3 clocks with `led` forced high beforehand -> `led`=0 immediately, no clock needed, and it stays 0 while in reset.
- `DUTY_PCT`=50, so `PERIOD`=10 -> after release `led` is 1 for 5 clocks then 0 for 5 clocks, repeating; check 4 full periods.
- `DUTY_PCT`=30 -> 3 clocks high, 7 low; the rising edges of `led` are exactly 10 clocks apart.
- `DUTY_PCT`=0 -> `led` stays 0 for 50 clocks. `DUTY_PCT`=100 -> `led` stays 1 for 50 clocks after the first edge.
- Mid-operation reset: assert `rst_n` during the 3rd high cycle -> `led`=0 asynchronously; after release the high phase restarts with its full 5 cycles.
- Defaults (100 MHz, 1 Hz, 50 %) -> `led` toggles every 50_000_000 clocks; measure 2 transitions at a 20 ns clock.

Source files
------------

// File: rtl/blink_pkg.sv
// Shared elaboration helpers for the status-LED blinker: period, on-time and counter width.
// All arithmetic is done on 64-bit values so large clock rates cannot overflow the duty product.
package blink_pkg;

   function automatic int blink_period(longint clk_hz, longint blink_hz);
      if (blink_hz == 0) return 0;
      return int'(clk_hz / blink_hz);
   endfunction

   function automatic int blink_on_cycles(int period, int duty_pct);
      longint prod;
      prod = longint'(period) * longint'(duty_pct);
      return int'(prod / 64'sd100);
   endfunction

   // Counter width for values 0..period-1, never narrower than one bit.
   function automatic int blink_cnt_w(int period);
      return (period > 1) ? $clog2(period) : 1;
   endfunction

endpackage

// File: rtl/blink_period_ctr.sv
// Modulo-PERIOD free-running counter with a wrap flag on the last count of each period.
// Reset is asynchronous and active-low.
module blink_period_ctr
   import blink_pkg::*;
#(
   parameter int  PERIOD = 10,
   localparam int CW     = blink_cnt_w(PERIOD)
)(
   input  logic          clk,
   input  logic          rst_n,
   output logic [CW-1:0] cnt,
   output logic          wrap
);

   localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

   logic [CW-1:0] cnt_reg;
   logic [CW-1:0] cnt_next;

   always_comb begin
      cnt_next = cnt_reg + 1'b1;
      if (cnt_reg == LAST) cnt_next = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_reg <= '0;
      else        cnt_reg <= cnt_next;
   end

   assign cnt  = cnt_reg;
   assign wrap = (cnt_reg == LAST);

endmodule

// File: rtl/blink.sv
// Free-running status-LED blinker: fixed-rate, fixed-duty square wave on an active-high LED.
// The LED comes straight from a flop, one cycle behind the period counter.
module blink
   import blink_pkg::*;
#(
   parameter longint CLK_HZ   = 100_000_000,
   parameter longint BLINK_HZ = 1,
   parameter int     DUTY_PCT = 50
)(
   input  logic clk,
   input  logic rst_n,
   output logic led
);

   localparam int PERIOD = blink_period(CLK_HZ, BLINK_HZ);
   localparam int ON_CYC = blink_on_cycles(PERIOD, DUTY_PCT);
   localparam int CW     = blink_cnt_w(PERIOD);

   // One extra bit so ON_CYC == PERIOD (full duty) is representable.
   localparam logic [CW:0] ON_CMP  = ON_CYC[CW:0];
   localparam logic        LAST_ON = (ON_CYC >= PERIOD);

   if (BLINK_HZ == 0) begin : g_bad_blink_hz
      $error("blink: BLINK_HZ must be nonzero");
   end
   if (PERIOD < 2) begin : g_bad_period
      $error("blink: CLK_HZ / BLINK_HZ must be at least 2");
   end
   if (DUTY_PCT > 100) begin : g_bad_duty
      $error("blink: DUTY_PCT must be in 0..100");
   end

   logic [CW-1:0] cnt;
   logic          wrap;
   logic          led_reg;
   logic          led_next;

   blink_period_ctr #(
      .PERIOD (PERIOD)
   ) u_ctr (
      .clk   (clk),
      .rst_n (rst_n),
      .cnt   (cnt),
      .wrap  (wrap)
   );

   // On the final count the comparison is only true at full duty, so it folds to a constant.
   always_comb begin
      led_next = ({1'b0, cnt} < ON_CMP);
      if (wrap) led_next = LAST_ON;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) led_reg <= 1'b0;
      else        led_reg <= led_next;
   end

   assign led = led_reg;

endmodule

// File: tb/tb_blink.sv
// Scoreboard bench for blink: five instances (50/30/0/100 % at 10 Hz clock, plus defaults)
// share clock and reset; expected LED levels are queued before each edge and compared after it.
module tb_blink;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic led50, led30, led0, led100, leddef;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int   lane;
      logic exp;
   } exp_t;

   exp_t   sb[$];
   int     mcnt;
   longint mdef;
   int     cyc;
   int     last_rise;
   logic   prev30;

   always #10 clk = ~clk;

   blink #(.CLK_HZ(10), .BLINK_HZ(1), .DUTY_PCT(50))  u50  (.clk(clk), .rst_n(rst_n), .led(led50));
   blink #(.CLK_HZ(10), .BLINK_HZ(1), .DUTY_PCT(30))  u30  (.clk(clk), .rst_n(rst_n), .led(led30));
   blink #(.CLK_HZ(10), .BLINK_HZ(1), .DUTY_PCT(0))   u0   (.clk(clk), .rst_n(rst_n), .led(led0));
   blink #(.CLK_HZ(10), .BLINK_HZ(1), .DUTY_PCT(100)) u100 (.clk(clk), .rst_n(rst_n), .led(led100));
   blink udef (.clk(clk), .rst_n(rst_n), .led(leddef));

   task automatic check(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s observed %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic string lane_name(input int lane);
      case (lane)
         0:       return "led_duty50";
         1:       return "led_duty30";
         2:       return "led_duty0";
         3:       return "led_duty100";
         default: return "led_default";
      endcase
   endfunction

   function automatic logic obs(input int lane);
      case (lane)
         0:       return led50;
         1:       return led30;
         2:       return led0;
         3:       return led100;
         default: return leddef;
      endcase
   endfunction

   task automatic model_restart();
      mcnt      = 0;
      mdef      = 0;
      cyc       = 0;
      last_rise = -1;
      prev30    = 1'b0;
   endtask

   // Called between edges: predict, let one edge pass, then compare.
   task automatic cycle();
      exp_t e;
      sb.push_back('{0, logic'(mcnt < 5)});
      sb.push_back('{1, logic'(mcnt < 3)});
      sb.push_back('{2, 1'b0});
      sb.push_back('{3, 1'b1});
      sb.push_back('{4, logic'(mdef < 64'd50_000_000)});
      mcnt = (mcnt == 9) ? 0 : mcnt + 1;
      mdef = (mdef == 64'd99_999_999) ? 0 : mdef + 1;
      @(posedge clk);
      #1;
      cyc++;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check(lane_name(e.lane), longint'(obs(e.lane)), longint'(e.exp));
      end
      if (led30 && !prev30) begin
         if (last_rise >= 0) check("duty30_rise_gap", cyc - last_rise, 10);
         last_rise = cyc;
      end
      prev30 = led30;
   endtask

   task automatic check_all_low(input string tag);
      check({tag, "_duty50"},  longint'(led50),  0);
      check({tag, "_duty30"},  longint'(led30),  0);
      check({tag, "_duty100"}, longint'(led100), 0);
      check({tag, "_default"}, longint'(leddef), 0);
   endtask

   initial begin
      model_restart();
      @(posedge clk);
      #1;
      check_all_low("reset_initial");
      @(posedge clk);
      #5;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) cycle();

      // Full-period reset with the LED known to be lit.
      check("pre_reset_duty50", longint'(led50), 1);
      #3;
      rst_n = 1'b0;
      #1;
      check_all_low("reset_async");
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check_all_low("reset_hold");
      end
      #4;
      rst_n = 1'b1;
      model_restart();
      for (int i = 0; i < 50; i++) cycle();

      // Mid-period reset during the third high cycle.
      for (int i = 0; i < 3; i++) cycle();
      check("mid_pre_duty50", longint'(led50), 1);
      #4;
      rst_n = 1'b0;
      #1;
      check("mid_reset_async", longint'(led50), 0);
      @(posedge clk);
      #1;
      check("mid_reset_hold", longint'(led50), 0);
      #5;
      rst_n = 1'b1;
      model_restart();
      for (int i = 0; i < 40; i++) cycle();

      // Longer run: default instance must stay lit well into its half-period.
      for (int i = 0; i < 200; i++) cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
